rv_ifu_prefetch: RTL and testbench

- Instruction fetch unit that sits directly upstream of the core's IF/ID pipeline register.
- Replaces the zero-latency instruction ROM path with a handshake memory port.
- Issues sequential 32-bit fetch requests and tracks outstanding requests.
- Buffers in-order responses in a prefetch FIFO and delivers {instr, pc} to decode over valid/ready.
- On a branch/jump redirect, restarts fetch and discards stale in-flight responses.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/rv_sync_fifo.sv | 71 +++++++
 rtl/rv_ifu_prefetch.sv | 150 +++++++++++++++
 tb/tb_rv_ifu_prefetch.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice: machine widths,
// prefetch FSM states, the buffered {instr, pc} entry and a PC alignment helper.
// Optional feature macro used by the fetch unit: RV_IFU_BYPASS_EN.
package rv_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

    // Clear the sub-word byte offset so every fetch address is instruction aligned
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INSTR_BYTES - 1));
    endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Single-clock FIFO with synchronous clear and an occupancy count.
// The head entry is presented combinationally from registered storage, so data
// written on one edge is visible at the output from the following cycle.
// A pop on an empty FIFO is ignored; push and pop together at full are legal.
module rv_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Entry storage: written at the tail on every accepted push
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rv_ifu_prefetch.sv
// Instruction prefetch unit feeding the IF/ID register. Issues sequential word
// fetches over a valid/ready memory port, limits outstanding requests so every
// response is guaranteed a buffer slot, buffers in-order responses and hands
// {instr, pc} to decode. A redirect flushes the buffer and drops in-flight
// responses by counting them out in the DRAIN state.
// Optional: define RV_IFU_BYPASS_EN to forward a response straight to decode
// when nothing is buffered or being discarded and decode is ready.
module rv_ifu_prefetch
    import rv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUTS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [XLEN-1:0]  mem_req_addr_o,
    input  logic             mem_rsp_valid_i,
    input  logic [ILEN-1:0]  mem_rsp_data_i,
    output logic             instr_valid_o,
    output logic [ILEN-1:0]  instr_o,
    output logic [XLEN-1:0]  instr_pc_o,
    input  logic             instr_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int FW = $bits(fifo_entry_t);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outs_q, outs_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    fifo_entry_t     push_entry;
    fifo_entry_t     head_entry;

    logic            req_fire;
    logic            rsp_drop;
    logic            credit_ok;
    logic            bypass;

    // A request is allowed only if its eventual response already has a FIFO slot
    assign credit_ok = (outs_q < CW'(MAX_OUTS)) &&
                       ((SW'(outs_q) + SW'(fifo_count)) < SW'(DEPTH));

    assign mem_req_valid_o = rstn & (state_q == FETCH) & ~redirect_i & credit_ok;
    assign mem_req_addr_o  = fetch_pc_q;
    assign req_fire        = mem_req_valid_o & mem_req_ready_i;

    assign rsp_drop = mem_rsp_valid_i & (discard_q != '0);

`ifdef RV_IFU_BYPASS_EN
    assign bypass = mem_rsp_valid_i & fifo_empty & (discard_q == '0) &
                    instr_ready_i & ~redirect_i;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry.instr = mem_rsp_data_i;
    assign push_entry.pc    = rsp_pc_q;

    assign fifo_push = mem_rsp_valid_i & ~rsp_drop & ~redirect_i & ~bypass &
                       (~fifo_full | fifo_pop);
    assign fifo_pop  = ~fifo_empty & ~redirect_i & instr_ready_i;

    rv_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .clear_i (redirect_i),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_valid_o = (~fifo_empty & ~redirect_i) | bypass;
    assign instr_o       = bypass ? mem_rsp_data_i :
                           (fifo_empty ? '0 : head_entry.instr);
    assign instr_pc_o    = bypass ? rsp_pc_q :
                           (fifo_empty ? '0 : head_entry.pc);

    // State register for the fetch PCs, credit counters and FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outs_q     <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state logic: redirect overrides normal issue/response bookkeeping
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outs_d     = outs_q + CW'(req_fire) - CW'(mem_rsp_valid_i);
        discard_d  = discard_q;

        if (redirect_i) begin
            // Everything still in flight after this cycle is stale
            fetch_pc_d = align_pc(redirect_pc_i);
            rsp_pc_d   = align_pc(redirect_pc_i);
            discard_d  = outs_q - CW'(mem_rsp_valid_i);
            state_d    = (discard_d != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (mem_rsp_valid_i) begin
                if (rsp_drop) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + PC_STEP;
                end
            end
            case (state_q)
                FETCH:   state_d = FETCH;
                DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_ifu_prefetch.sv
// Directed bench for rv_ifu_prefetch: a behavioural memory with configurable
// response latency answers each accepted request in order; every delivered
// {pc, instr} is recorded and compared against hand-derived sequences.
// A second instance with a top-of-memory reset PC shares the stimulus so the
// address wrap-around can be observed alongside the main run.
module tb_rv_ifu_prefetch;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
`ifdef RV_IFU_BYPASS_EN
    localparam logic C1_VALID = 1'b1;
`else
    localparam logic C1_VALID = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } del_t;

    logic        clk;
    logic        rstn;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        instr_ready_i;

    logic        mem_req_valid_o;
    logic [63:0] mem_req_addr_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;

    // Drive values applied at the next negedge by cycle()
    logic        drv_ready, drv_iready, drv_redirect, drv_hold;
    logic [63:0] drv_rpc;
    int          drv_lat;

    // Samples taken 1 ns after the drive point, well away from posedge
    logic        s_req_v, s_iv, s_rsp, s_wv;
    logic [63:0] s_addr, s_ipc, s_waddr;
    logic [31:0] s_instr;

    logic [63:0] pend_addr[$];
    int          pend_due[$];
    del_t        del_q[$];
    int          cyc;
    int          rsp_total;
    int          tests_run;
    int          tests_failed;

    rv_ifu_prefetch #(
        .RESET_PC (64'h0),
        .DEPTH    (4),
        .MAX_OUTS (2)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    rv_ifu_prefetch #(
        .RESET_PC (WRAP_PC),
        .DEPTH    (4),
        .MAX_OUTS (2)
    ) dut_wrap (
        .clk             (clk),
        .rstn            (rstn),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (w_req_valid),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (w_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .instr_valid_o   (w_instr_valid),
        .instr_o         (w_instr),
        .instr_pc_o      (w_instr_pc),
        .instr_ready_i   (instr_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h0000_0013 + (a[31:0] << 5);
    endfunction

    task automatic cycle();
        del_t d;
        @(negedge clk);
        if (pend_addr.size() > 0 && !drv_hold && cyc >= pend_due[0]) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(pend_addr[0]);
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
        end
        mem_req_ready_i = drv_ready;
        instr_ready_i   = drv_iready;
        redirect_i      = drv_redirect;
        redirect_pc_i   = drv_rpc;
        #1;
        s_req_v = mem_req_valid_o;
        s_addr  = mem_req_addr_o;
        s_iv    = instr_valid_o;
        s_instr = instr_o;
        s_ipc   = instr_pc_o;
        s_rsp   = mem_rsp_valid_i;
        s_wv    = w_req_valid;
        s_waddr = w_req_addr;
        if (mem_rsp_valid_i) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            rsp_total++;
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            pend_addr.push_back(mem_req_addr_o);
            pend_due.push_back(cyc + drv_lat);
        end
        if (instr_valid_o && instr_ready_i) begin
            d.pc    = instr_pc_o;
            d.instr = instr_o;
            del_q.push_back(d);
        end
        drv_redirect = 1'b0;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn            = 1'b0;
        redirect_i      = 1'b0;
        redirect_pc_i   = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        instr_ready_i   = 1'b0;
        drv_ready = 0; drv_iready = 0; drv_redirect = 0; drv_hold = 0;
        drv_rpc = '0; drv_lat = 1;
        pend_addr.delete();
        pend_due.delete();
        del_q.delete();
        rsp_total = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cyc  = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        rstn = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (mem_req_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_valid: got %0b expected 0", mem_req_valid_o);
        end
        tests_run++;
        if (instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_instr_valid: got %0b expected 0", instr_valid_o);
        end
        tests_run++;
        if (instr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_instr: got %h expected 00000000", instr_o);
        end
        tests_run++;
        if (instr_pc_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_instr_pc: got %h expected 0", instr_pc_o);
        end
        apply_reset();
        cycle();
        tests_run++;
        if (s_req_v !== 1'b1 || s_addr !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_first_req: got v=%0b addr=%h expected v=1 addr=0", s_req_v, s_addr);
        end
        tests_run++;
        if (s_wv !== 1'b1 || s_waddr !== WRAP_PC) begin
            tests_failed++;
            $display("FAIL reset_wrap_req: got v=%0b addr=%h expected v=1 addr=%h", s_wv, s_waddr, WRAP_PC);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_streaming();
        int gaps;
        apply_reset();
        drv_ready = 1; drv_iready = 1; drv_lat = 1;
        cycle();
        tests_run++;
        if (s_addr !== 64'h0 || s_waddr !== WRAP_PC) begin
            tests_failed++;
            $display("FAIL stream_c0_addr: got %h/%h expected 0/%h", s_addr, s_waddr, WRAP_PC);
        end
        cycle();
        tests_run++;
        if (s_waddr !== 64'hFFFF_FFFF_FFFF_FFFC || s_wv !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_c1_addr: got v=%0b %h expected v=1 fffffffffffffffc", s_wv, s_waddr);
        end
        tests_run++;
        if (s_iv !== C1_VALID) begin
            tests_failed++;
            $display("FAIL stream_first_latency: got valid=%0b expected %0b", s_iv, C1_VALID);
        end
        cycle();
        tests_run++;
        if (s_waddr !== 64'h0 || s_wv !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_c2_addr: got v=%0b %h expected v=1 0", s_wv, s_waddr);
        end
        tests_run++;
        if (s_iv !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_c2_valid: got %0b expected 1", s_iv);
        end
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_iv !== 1'b1) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps);
        end
        tests_run++;
        if (del_q.size() < 16) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d deliveries expected >=16", del_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                tests_run++;
                if (del_q[i].pc !== 64'(4 * i) || del_q[i].instr !== mem_word(64'(4 * i))) begin
                    tests_failed++;
                    $display("FAIL stream_entry[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                             i, del_q[i].pc, del_q[i].instr, 64'(4 * i), mem_word(64'(4 * i)));
                end
            end
        end
        $display("[TB] test_streaming done: %0d instructions delivered", del_q.size());
    endtask

    task automatic test_back_pressure();
        int over;
        apply_reset();
        drv_ready = 1; drv_iready = 0; drv_lat = 1;
        over = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (pend_addr.size() + rsp_total > 4) over++;
        end
        tests_run++;
        if (over !== 0) begin
            tests_failed++;
            $display("FAIL bp_credit: got %0d over-credit cycles expected 0", over);
        end
        tests_run++;
        if (rsp_total !== 4 || pend_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_buffered: got %0d buffered %0d outstanding expected 4 and 0", rsp_total, pend_addr.size());
        end
        tests_run++;
        if (s_req_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_req_drop: got req_valid=%0b expected 0", s_req_v);
        end
        tests_run++;
        if (s_iv !== 1'b1 || s_ipc !== 64'h0 || s_instr !== 32'h0000_0013) begin
            tests_failed++;
            $display("FAIL bp_head: got v=%0b pc=%h instr=%h expected v=1 pc=0 instr=00000013", s_iv, s_ipc, s_instr);
        end
        drv_iready = 1;
        repeat (10) cycle();
        tests_run++;
        if (del_q.size() < 8) begin
            tests_failed++;
            $display("FAIL bp_release_count: got %0d deliveries expected >=8", del_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (del_q[i].pc !== 64'(4 * i) || del_q[i].instr !== mem_word(64'(4 * i))) begin
                    tests_failed++;
                    $display("FAIL bp_entry[%0d]: got pc=%h instr=%h expected pc=%h", i, del_q[i].pc, del_q[i].instr, 64'(4 * i));
                end
            end
        end
        $display("[TB] test_back_pressure done");
    endtask

    task automatic test_redirect_drain();
        apply_reset();
        drv_ready = 1; drv_iready = 1; drv_lat = 1; drv_hold = 1;
        cycle();
        cycle();
        cycle();
        tests_run++;
        if (s_req_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_max_outs: got req_valid=%0b expected 0", s_req_v);
        end
        drv_redirect = 1; drv_rpc = 64'h1000;
        cycle();
        tests_run++;
        if (s_req_v !== 1'b0 || s_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_redirect_cycle: got req=%0b iv=%0b expected 0 0", s_req_v, s_iv);
        end
        drv_hold = 0;
        cycle();
        tests_run++;
        if (s_req_v !== 1'b0 || s_rsp !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_drain1: got req=%0b rsp=%0b expected 0 1", s_req_v, s_rsp);
        end
        cycle();
        tests_run++;
        if (s_req_v !== 1'b0 || s_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_drain2: got req=%0b iv=%0b expected 0 0", s_req_v, s_iv);
        end
        cycle();
        tests_run++;
        if (s_req_v !== 1'b1 || s_addr !== 64'h1000 || del_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL rd_restart: got req=%0b addr=%h dels=%0d expected 1 1000 0", s_req_v, s_addr, del_q.size());
        end
        repeat (6) cycle();
        tests_run++;
        if (del_q.size() < 2) begin
            tests_failed++;
            $display("FAIL rd_deliver_count: got %0d expected >=2", del_q.size());
        end else begin
            tests_run++;
            if (del_q[0].pc !== 64'h1000 || del_q[0].instr !== mem_word(64'h1000) || del_q[1].pc !== 64'h1004) begin
                tests_failed++;
                $display("FAIL rd_deliver: got %h/%h then %h expected 1000/%h then 1004",
                         del_q[0].pc, del_q[0].instr, del_q[1].pc, mem_word(64'h1000));
            end
        end
        $display("[TB] test_redirect_drain done");
    endtask

    task automatic test_redirect_same_cycle();
        apply_reset();
        drv_ready = 1; drv_iready = 0; drv_lat = 3;
        repeat (7) cycle();
        tests_run++;
        if (s_iv !== 1'b1 || pend_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL rs_setup: got iv=%0b outstanding=%0d expected 1 2", s_iv, pend_addr.size());
        end
        drv_redirect = 1; drv_rpc = 64'h2003; drv_iready = 1;
        cycle();
        tests_run++;
        if (s_rsp !== 1'b1 || s_iv !== 1'b0 || s_req_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL rs_redirect_cycle: got rsp=%0b iv=%0b req=%0b expected 1 0 0", s_rsp, s_iv, s_req_v);
        end
        cycle();
        tests_run++;
        if (s_iv !== 1'b0 || s_req_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL rs_drain: got iv=%0b req=%0b expected 0 0", s_iv, s_req_v);
        end
        cycle();
        tests_run++;
        if (s_req_v !== 1'b1 || s_addr !== 64'h2000 || del_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL rs_restart: got req=%0b addr=%h dels=%0d expected 1 2000 0", s_req_v, s_addr, del_q.size());
        end
        repeat (7) cycle();
        tests_run++;
        if (del_q.size() < 1) begin
            tests_failed++;
            $display("FAIL rs_deliver_count: got %0d expected >=1", del_q.size());
        end else begin
            tests_run++;
            if (del_q[0].pc !== 64'h2000 || del_q[0].instr !== mem_word(64'h2000)) begin
                tests_failed++;
                $display("FAIL rs_deliver: got %h/%h expected 2000/%h", del_q[0].pc, del_q[0].instr, mem_word(64'h2000));
            end
        end
        $display("[TB] test_redirect_same_cycle done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drv_ready = 1; drv_iready = 1; drv_lat = 1;
        repeat (5) cycle();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (mem_req_valid_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got req=%0b iv=%0b instr=%h expected 0 0 0",
                     mem_req_valid_o, instr_valid_o, instr_o);
        end
        apply_reset();
        drv_ready = 1; drv_iready = 1; drv_lat = 1;
        repeat (4) cycle();
        tests_run++;
        if (del_q.size() < 1 || del_q[0].pc !== 64'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_restart: got dels=%0d expected first pc 0", del_q.size());
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn         = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
